// File: rtl/beat_qualifier.sv
// Heartbeat front end: synchronises and debounces the raw sensor pulse, applies a
// refractory lockout and emits one single-cycle beat_pulse per qualified beat.
module beat_qualifier #(
    parameter int unsigned DEBOUNCE_MS   = 4,
    parameter int unsigned REFRACTORY_MS = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1ms,
    input  logic       enable,
    input  logic       count_clr,
    input  logic       beat_raw,
    output logic       beat_pulse,
    output logic       lockout,
    output logic [7:0] beat_count,
    output logic [3:0] reject_count
);

    localparam int unsigned DB_W   = 4;
    localparam int unsigned REF_W  = 10;
    localparam int unsigned BEAT_W = 8;
    localparam int unsigned REJ_W  = 4;

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [REF_W-1:0]  REF_LOAD = REF_W'(REFRACTORY_MS);
    localparam logic [BEAT_W-1:0] BEAT_MAX = '1;
    localparam logic [REJ_W-1:0]  REJ_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCKOUT  = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t            state;
    logic              beat_meta;
    logic              beat_s;
    logic              beat_db;
    logic              beat_db_q;
    logic [DB_W-1:0]   db_cnt;
    logic [REF_W-1:0]  ref_cnt;
    logic              rise_c;

    // Two-flop synchroniser for the asynchronous sensor input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_meta <= 1'b0;
            beat_s    <= 1'b0;
        end else begin
            beat_meta <= beat_raw;
            beat_s    <= beat_meta;
        end
    end

    // Tick-based debouncer; any return to agreement restarts the hold count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_db   <= 1'b0;
            beat_db_q <= 1'b0;
            db_cnt    <= '0;
        end else begin
            beat_db_q <= beat_db;
            if (beat_s == beat_db) begin
                db_cnt <= '0;
            end else if (tick_1ms) begin
                if (db_cnt == DB_LAST) begin
                    beat_db <= beat_s;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end
    end

    assign rise_c = beat_db & ~beat_db_q;

    // Qualifier FSM; lockout tracks the state being entered so it is registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ref_cnt    <= '0;
            beat_pulse <= 1'b0;
            lockout    <= 1'b0;
        end else begin
            beat_pulse <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                lockout <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise_c) begin
                            beat_pulse <= 1'b1;
                            ref_cnt    <= REF_LOAD;
                            state      <= LOCKOUT;
                            lockout    <= 1'b1;
                        end
                    end
                    LOCKOUT: begin
                        if (tick_1ms) begin
                            ref_cnt <= ref_cnt - REF_W'(1);
                            if (ref_cnt == REF_W'(1)) begin
                                if (beat_db) begin
                                    state <= WAIT_LOW;
                                end else begin
                                    state   <= IDLE;
                                    lockout <= 1'b0;
                                end
                            end
                        end
                    end
                    WAIT_LOW: begin
                        if (!beat_db) begin
                            state   <= IDLE;
                            lockout <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        lockout <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating statistics counters; a clear overrides a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count   <= '0;
            reject_count <= '0;
        end else if (count_clr) begin
            beat_count   <= '0;
            reject_count <= '0;
        end else if (enable && rise_c) begin
            if (state == IDLE && beat_count != BEAT_MAX) begin
                beat_count <= beat_count + BEAT_W'(1);
            end
            if (state == LOCKOUT && reject_count != REJ_MAX) begin
                reject_count <= reject_count + REJ_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_beat_qualifier.sv
// Directed bench for beat_qualifier: vector table of beat scenarios plus
// hand-written sequences for latency, lockout length, clear, saturation and reset.
module tb_beat_qualifier;

    localparam int unsigned DEB = 4;
    localparam int unsigned REF = 30;

    logic       clk;
    logic       rst_n;
    logic       tick_1ms;
    logic       enable;
    logic       count_clr;
    logic       beat_raw;
    logic       beat_pulse;
    logic       lockout;
    logic [7:0] beat_count;
    logic [3:0] reject_count;

    int n_checks;
    int n_fail;
    int cyc;
    int tick_per;
    int pulse_total;
    int pulse_wide;
    int lock_ticks;
    logic pulse_prev;

    beat_qualifier #(
        .DEBOUNCE_MS  (DEB),
        .REFRACTORY_MS(REF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1ms    (tick_1ms),
        .enable      (enable),
        .count_clr   (count_clr),
        .beat_raw    (beat_raw),
        .beat_pulse  (beat_pulse),
        .lockout     (lockout),
        .beat_count  (beat_count),
        .reject_count(reject_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe pre-edge values: pulse count, pulse width, ticks seen while locked out
    always @(posedge clk) begin
        if (beat_pulse) pulse_total = pulse_total + 1;
        if (beat_pulse && pulse_prev) pulse_wide = pulse_wide + 1;
        pulse_prev = beat_pulse;
        if (lockout && tick_1ms) lock_ticks = lock_ticks + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int hi;
        int lo;
        bit en;
        int exp_pulses;
        int exp_beats;
        int exp_rej;
        bit exp_lock;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; inputs change on the falling edge, tick strobes every tick_per cycles
    task automatic step();
        @(negedge clk);
        cyc = cyc + 1;
        tick_1ms = ((cyc % tick_per) == 0);
    endtask

    // Returns on the falling edge where the n-th tick is presented
    task automatic tick_wait(input int n);
        int k;
        k = 0;
        while (k < n) begin
            step();
            if (tick_1ms) k = k + 1;
        end
    endtask

    task automatic beat(input int hi, input int lo);
        beat_raw = 1'b1;
        tick_wait(hi);
        beat_raw = 1'b0;
        tick_wait(lo);
    endtask

    vec_t vecs[8];

    initial begin
        int p0;
        int l0;
        int lat;

        vecs[0] = '{hi: 4,  lo: 40, en: 1'b1, exp_pulses: 1, exp_beats: 2, exp_rej: 0, exp_lock: 1'b0};
        vecs[1] = '{hi: 3,  lo: 20, en: 1'b1, exp_pulses: 0, exp_beats: 2, exp_rej: 0, exp_lock: 1'b0};
        vecs[2] = '{hi: 6,  lo: 6,  en: 1'b1, exp_pulses: 1, exp_beats: 3, exp_rej: 0, exp_lock: 1'b1};
        vecs[3] = '{hi: 6,  lo: 40, en: 1'b1, exp_pulses: 0, exp_beats: 3, exp_rej: 1, exp_lock: 1'b0};
        vecs[4] = '{hi: 6,  lo: 40, en: 1'b1, exp_pulses: 1, exp_beats: 4, exp_rej: 1, exp_lock: 1'b0};
        vecs[5] = '{hi: 60, lo: 40, en: 1'b1, exp_pulses: 1, exp_beats: 5, exp_rej: 1, exp_lock: 1'b0};
        vecs[6] = '{hi: 10, lo: 40, en: 1'b0, exp_pulses: 0, exp_beats: 5, exp_rej: 1, exp_lock: 1'b0};
        vecs[7] = '{hi: 8,  lo: 40, en: 1'b1, exp_pulses: 1, exp_beats: 6, exp_rej: 1, exp_lock: 1'b0};

        n_checks = 0; n_fail = 0; cyc = 0; tick_per = 10;
        pulse_total = 0; pulse_wide = 0; lock_ticks = 0; pulse_prev = 1'b0;
        rst_n = 1'b0; enable = 1'b1; count_clr = 1'b0; beat_raw = 1'b0; tick_1ms = 1'b0;

        repeat (5) step();
        check("rst_pulse", int'(beat_pulse), 0);
        check("rst_lockout", int'(lockout), 0);
        check("rst_beat_count", int'(beat_count), 0);
        check("rst_reject_count", int'(reject_count), 0);
        rst_n = 1'b1;
        tick_wait(1);

        // Clean beat: latency from raw rise and lockout length in ticks
        l0 = lock_ticks;
        beat_raw = 1'b1;
        lat = 0;
        while (!beat_pulse && lat < 500) begin
            step();
            lat = lat + 1;
        end
        check("latency_cycles", lat, int'(DEB) * tick_per + 2);
        check("lockout_with_pulse", int'(lockout), 1);
        step();
        check("pulse_one_cycle", int'(beat_pulse), 0);
        tick_wait(10);
        beat_raw = 1'b0;
        tick_wait(40);
        check("lockout_ticks", lock_ticks - l0, int'(REF));
        check("clean_beat_count", int'(beat_count), 1);
        check("clean_lockout_end", int'(lockout), 0);

        for (int i = 0; i < 8; i++) begin
            p0 = pulse_total;
            enable = vecs[i].en;
            beat(vecs[i].hi, vecs[i].lo);
            check($sformatf("v%0d_pulses", i), pulse_total - p0, vecs[i].exp_pulses);
            check($sformatf("v%0d_beat_count", i), int'(beat_count), vecs[i].exp_beats);
            check($sformatf("v%0d_reject_count", i), int'(reject_count), vecs[i].exp_rej);
            check($sformatf("v%0d_lockout", i), int'(lockout), int'(vecs[i].exp_lock));
        end

        // Held input: stays locked out past the refractory period until release debounces
        p0 = pulse_total;
        beat_raw = 1'b1;
        tick_wait(50);
        check("held_wait_low", int'(lockout), 1);
        beat_raw = 1'b0;
        tick_wait(int'(DEB));
        check("held_before_release", int'(lockout), 1);
        step();
        step();
        check("held_released", int'(lockout), 0);
        check("held_pulses", pulse_total - p0, 1);
        check("held_beat_count", int'(beat_count), 7);
        tick_wait(40);

        // Enable dropped mid-lockout returns to idle on the next cycle
        p0 = pulse_total;
        beat_raw = 1'b1;
        tick_wait(6);
        beat_raw = 1'b0;
        tick_wait(6);
        check("en_lockout_before", int'(lockout), 1);
        enable = 1'b0;
        step();
        check("en_lockout_dropped", int'(lockout), 0);
        beat(6, 20);
        enable = 1'b1;
        tick_wait(20);
        check("en_pulses", pulse_total - p0, 1);
        check("en_beat_count", int'(beat_count), 8);
        check("en_lockout_after", int'(lockout), 0);

        // Clear coincident with the beat's rise cycle
        beat_raw = 1'b1;
        tick_wait(int'(DEB));
        step();
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        check("clr_pulse", int'(beat_pulse), 1);
        check("clr_beat_count", int'(beat_count), 0);
        check("clr_reject_count", int'(reject_count), 0);
        tick_wait(6);
        beat_raw = 1'b0;
        tick_wait(40);

        // Two rejected rises per beat drive reject_count into saturation
        p0 = pulse_total;
        for (int it = 0; it < 8; it++) begin
            beat(5, 5);
            beat(5, 5);
            beat(5, 20);
            if (it == 6) check("rej_count_14", int'(reject_count), 14);
        end
        check("rej_sat_15", int'(reject_count), 15);
        check("rej_beats", pulse_total - p0, 8);
        check("rej_beat_count", int'(beat_count), 8);

        // beat_count saturation with faster ticks
        tick_per = 2;
        tick_wait(1);
        p0 = pulse_total;
        for (int b = 0; b < 260; b++) begin
            beat(6, 34);
            if (b == 246) check("sat_count_255", int'(beat_count), 255);
        end
        check("sat_pulses", pulse_total - p0, 260);
        check("sat_beat_count", int'(beat_count), 255);
        tick_per = 10;
        tick_wait(1);

        // Asynchronous reset in lockout with the sensor held high through release
        beat_raw = 1'b1;
        tick_wait(10);
        check("rstmid_lockout_before", int'(lockout), 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_lockout", int'(lockout), 0);
        check("rstmid_beat_count", int'(beat_count), 0);
        check("rstmid_reject_count", int'(reject_count), 0);
        check("rstmid_pulse", int'(beat_pulse), 0);
        repeat (3) step();
        rst_n = 1'b1;
        p0 = pulse_total;
        tick_wait(12);
        check("rstrel_pulses", pulse_total - p0, 1);
        check("rstrel_beat_count", int'(beat_count), 1);
        check("rstrel_lockout", int'(lockout), 1);
        beat_raw = 1'b0;
        tick_wait(40);
        check("rstrel_lockout_end", int'(lockout), 0);

        check("pulse_width_violations", pulse_wide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
